multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM that sequences the RV32I datapath through fetch, decode, execute, memory and writeback over a single shared memory port with a ready handshake. It qualifies the combinational decoder's regWrite/MemRead/MemWrite/MemToReg outputs into per-cycle enables. It also enforces a memory timeout, halts at instruction boundaries on request, and counts retired instructions.

## Interface
- MEM_TIMEOUT, default 15: maximum consecutive not-ready cycles tolerated in a memory wait state; 0 disables the timeout.
- clk  in  1  rising-edge clock, the only clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instr[6:0] of the instruction register.
- dec_reg_write  in  1  decoder regWrite.
- dec_mem_read  in  1  decoder MemRead.
- dec_mem_write  in  1  decoder MemWrite.
- dec_mem_to_reg  in  1  decoder MemToReg.
- mem_ready  in  1  memory completes the current request this cycle.
- halt_req  in  1  level request to stop at the next instruction boundary.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write (meaningful only with mem_req).
- addr_sel  out  1  memory address mux: 0 = PC, 1 = ALU result.
- ir_we  out  1  load instruction register.
- pc_we  out  1  load PC with PC+4.
- reg_we  out  1  register file write enable.
- mem_to_reg  out  1  writeback mux: 1 = memory data.
- state  out  3  current FSM state, for debug.
- halted  out  1  FSM is in HALT.
- fault  out  1  sticky error flag.
- instret  out  32  retired instruction count.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6; codes 7 go to FAULT.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. ir_we=mem_ready. If ready, go to DECODE.
- DECODE: if opcode is one of 0110011, 0010011, 0000011 or 0100011, go to EXEC; otherwise go to FAULT.
- EXEC: if dec_mem_read or dec_mem_write is set, go to MEM; otherwise go to WB.
- MEM: mem_req=1, addr_sel=1, mem_we=dec_mem_write.
  - Load with ready: go to WB.
  - Store with ready: pc_we=1, instret+1, then a boundary check.
- WB: reg_we=dec_reg_write, mem_to_reg=dec_mem_to_reg, pc_we=1, instret+1, then a boundary check.
- Boundary check: if halt_req=1, go to HALT; otherwise go to FETCH.
- HALT: halted=1, all enables 0. When halt_req=0, go to FETCH.
- FAULT: fault=1, all enables 0. Absorbing; only rst_n exits it. halt_req is ignored.
- Timeout: wait_cnt is cleared on entry to FETCH or MEM and increments on each cycle with mem_ready=0. If mem_ready=0 while wait_cnt==MEM_TIMEOUT (and MEM_TIMEOUT≠0), go to FAULT. No memory transfer happens in that case.
- Output decode:
  - Moore on state: mem_req, addr_sel, mem_we, reg_we, mem_to_reg, halted, fault, state.
  - Mealy (gated by mem_ready): ir_we, and pc_we in MEM.
- Every output not listed for a state is 0.
- mem_ready outside FETCH/MEM is ignored.
- instret is unsigned and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (async assert, sync release): state=FETCH, wait_cnt=0, instret=0. fault, halted, reg_we, pc_we and ir_we are 0.
  - mem_req=1 and addr_sel=0 from reset onward.
- Latency with zero-wait memory:
  - R/I-ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles (FETCH, DECODE, EXEC, MEM, WB).
  - Store: 4 cycles (FETCH, DECODE, EXEC, MEM).
- Each not-ready cycle adds 1 cycle.
- Handshake: mem_req holds high, with stable address/we, until the cycle mem_ready=1. The transfer happens in that cycle, and the next cycle is already in the next state.
- With MEM_TIMEOUT=N, FAULT is entered after N+1 consecutive not-ready cycles. Ready on cycle N+1 of the wait (wait_cnt==N) completes normally.
- halt_req is sampled only in the retirement cycle. Assertion mid-instruction never stops that instruction.
- rst_n asserted mid-instruction aborts it. No pc_we/reg_we/instret update occurs on the interrupted instruction.

## Test plan
- ADDI (opcode 0010011), dec_reg_write=1, mem_ready tied 1:
  - states go 0,1,2,4,0.
  - ir_we in cycle 0.
  - reg_we and pc_we in cycle 3.
  - instret 0→1.
- LW with mem_ready low 3 cycles in MEM, MEM_TIMEOUT=15:
  - MEM lasts 4 cycles with mem_req=1, addr_sel=1, mem_we=0.
  - WB then has reg_we=1 and mem_to_reg=1.
  - Total 8 cycles.
- SW with ready immediately: MEM asserts mem_we=1, pc_we=1, reg_we=0, then returns to FETCH; instret increments.
- opcode 1100011 (branch, unsupported): DECODE→FAULT. fault=1 stays with all enables 0 for 20 cycles, and clears only on rst_n=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH: FAULT is entered after exactly 5 FETCH cycles, with no ir_we ever asserted.
- halt_req raised during EXEC of ADDI:
  - WB retires it (instret+1), then HALT with halted=1.
  - Dropping halt_req leads to FETCH next cycle.
  - Preloading instret near wrap (force 0xFFFFFFFF), one retire reads 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM.
// Sequences fetch/decode/execute/memory/writeback over one shared memory
// port with a ready handshake, qualifies the decoder's control bits into
// per-cycle enables, traps on memory timeout or unsupported opcodes, halts
// at instruction boundaries on request and counts retired instructions.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        dec_reg_write,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_mem_to_reg,
    input  logic        mem_ready,
    input  logic        halt_req,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        mem_to_reg,
    output logic [2:0]  state,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_wait_cnt;
    logic [31:0] r_instret;
    logic        w_timeout;
    logic        w_retire;
    logic        w_valid_op;
    logic        w_in_wait;

    // Only R-ALU, I-ALU, load and store are implemented; anything else traps.
    assign w_valid_op = (opcode == 7'b0110011) || (opcode == 7'b0010011) ||
                        (opcode == 7'b0000011) || (opcode == 7'b0100011);

    assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM);

    // Timeout fires on the not-ready cycle after MEM_TIMEOUT not-ready cycles.
    assign w_timeout = (MEM_TIMEOUT != 0) && !mem_ready &&
                       (r_wait_cnt == MEM_TIMEOUT);

    assign state   = r_state;
    assign instret = r_instret;

    // Next-state logic and per-state enables (Moore plus ready-gated Mealy).
    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_DECODE: begin
                w_next = w_valid_op ? S_EXEC : S_FAULT;
            end
            S_EXEC: begin
                w_next = (dec_mem_read || dec_mem_write) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = dec_mem_write;
                if (mem_ready) begin
                    if (dec_mem_write) begin
                        pc_we    = 1'b1;
                        w_retire = 1'b1;
                        w_next   = halt_req ? S_HALT : S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_WB: begin
                reg_we     = dec_reg_write;
                mem_to_reg = dec_mem_to_reg;
                pc_we      = 1'b1;
                w_retire   = 1'b1;
                w_next     = halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (!halt_req) w_next = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                w_next = S_FAULT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Wait counter: restarts on every state change, so entering FETCH or MEM
    // always begins from zero; saturates so a disabled timeout never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wait_cnt <= '0;
        else if (w_next != r_state)
            r_wait_cnt <= '0;
        else if (w_in_wait && !mem_ready && (r_wait_cnt != '1))
            r_wait_cnt <= r_wait_cnt + 32'd1;
    end

    // Retired instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_instret <= '0;
        else if (w_retire) r_instret <= r_instret + 32'd1;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed test of multicycle_ctrl with hand-computed
// expectations; a second instance exercises MEM_TIMEOUT=4.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg;
    logic        mem_ready, halt_req;

    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, mem_to_reg;
    logic [2:0]  state;
    logic        halted, fault;
    logic [31:0] instret;

    logic        t4_mem_req, t4_mem_we, t4_addr_sel, t4_ir_we, t4_pc_we, t4_reg_we, t4_mem_to_reg;
    logic [2:0]  t4_state;
    logic        t4_halted, t4_fault;
    logic [31:0] t4_instret;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write), .dec_mem_to_reg(dec_mem_to_reg),
        .mem_ready(mem_ready), .halt_req(halt_req),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
        .state(state), .halted(halted), .fault(fault), .instret(instret)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_t4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write), .dec_mem_to_reg(dec_mem_to_reg),
        .mem_ready(mem_ready), .halt_req(halt_req),
        .mem_req(t4_mem_req), .mem_we(t4_mem_we), .addr_sel(t4_addr_sel),
        .ir_we(t4_ir_we), .pc_we(t4_pc_we), .reg_we(t4_reg_we), .mem_to_reg(t4_mem_to_reg),
        .state(t4_state), .halted(t4_halted), .fault(t4_fault), .instret(t4_instret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Holds reset for two cycles, checks reset outputs, releases at a negedge.
    task automatic do_reset();
        rst_n          = 1'b0;
        mem_ready      = 1'b0;
        halt_req       = 1'b0;
        opcode         = '0;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst state",   {29'd0, state}, 32'd0);
        chk("rst mem_req", {31'd0, mem_req}, 32'd1);
        chk("rst addr_sel",{31'd0, addr_sel}, 32'd0);
        chk("rst ir_we",   {31'd0, ir_we}, 32'd0);
        chk("rst pc_we",   {31'd0, pc_we}, 32'd0);
        chk("rst reg_we",  {31'd0, reg_we}, 32'd0);
        chk("rst fault",   {31'd0, fault}, 32'd0);
        chk("rst halted",  {31'd0, halted}, 32'd0);
        chk("rst instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // ADDI, zero-wait memory
        do_reset();
        opcode = 7'b0010011; dec_reg_write = 1'b1; mem_ready = 1'b1;
        #1;
        chk("addi c0 state", {29'd0, state}, 32'd0);
        chk("addi c0 ir_we", {31'd0, ir_we}, 32'd1);
        chk("addi c0 pc_we", {31'd0, pc_we}, 32'd0);
        @(negedge clk); #1;
        chk("addi c1 state", {29'd0, state}, 32'd1);
        chk("addi c1 ir_we", {31'd0, ir_we}, 32'd0);
        @(negedge clk); #1;
        chk("addi c2 state", {29'd0, state}, 32'd2);
        @(negedge clk); #1;
        chk("addi c3 state",  {29'd0, state}, 32'd4);
        chk("addi c3 reg_we", {31'd0, reg_we}, 32'd1);
        chk("addi c3 pc_we",  {31'd0, pc_we}, 32'd1);
        chk("addi c3 instret", instret, 32'd0);
        @(negedge clk); #1;
        chk("addi c4 state",   {29'd0, state}, 32'd0);
        chk("addi c4 instret", instret, 32'd1);

        // LW with three not-ready cycles in MEM
        do_reset();
        opcode = 7'b0000011; dec_reg_write = 1'b1; dec_mem_read = 1'b1;
        dec_mem_to_reg = 1'b1; mem_ready = 1'b1;
        #1;
        chk("lw c0 ir_we", {31'd0, ir_we}, 32'd1);
        @(negedge clk); @(negedge clk);
        #1;
        chk("lw c2 state", {29'd0, state}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = (i == 3);
            #1;
            chk("lw mem state",    {29'd0, state}, 32'd3);
            chk("lw mem mem_req",  {31'd0, mem_req}, 32'd1);
            chk("lw mem addr_sel", {31'd0, addr_sel}, 32'd1);
            chk("lw mem mem_we",   {31'd0, mem_we}, 32'd0);
            chk("lw mem pc_we",    {31'd0, pc_we}, 32'd0);
        end
        @(negedge clk); #1;
        chk("lw wb state",      {29'd0, state}, 32'd4);
        chk("lw wb reg_we",     {31'd0, reg_we}, 32'd1);
        chk("lw wb mem_to_reg", {31'd0, mem_to_reg}, 32'd1);
        chk("lw wb pc_we",      {31'd0, pc_we}, 32'd1);
        @(negedge clk); #1;
        chk("lw done state",   {29'd0, state}, 32'd0);
        chk("lw done instret", instret, 32'd1);

        // SW, zero-wait
        do_reset();
        opcode = 7'b0100011; dec_mem_write = 1'b1; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("sw mem state",  {29'd0, state}, 32'd3);
        chk("sw mem mem_we", {31'd0, mem_we}, 32'd1);
        chk("sw mem pc_we",  {31'd0, pc_we}, 32'd1);
        chk("sw mem reg_we", {31'd0, reg_we}, 32'd0);
        @(negedge clk); #1;
        chk("sw done state",   {29'd0, state}, 32'd0);
        chk("sw done instret", instret, 32'd1);

        // Unsupported branch opcode traps and stays trapped
        do_reset();
        opcode = 7'b1100011; dec_reg_write = 1'b1; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            halt_req = i[0];
            #1;
            chk("br fault",   {31'd0, fault}, 32'd1);
            chk("br state",   {29'd0, state}, 32'd6);
            chk("br mem_req", {31'd0, mem_req}, 32'd0);
            chk("br ir_we",   {31'd0, ir_we}, 32'd0);
            chk("br pc_we",   {31'd0, pc_we}, 32'd0);
            chk("br reg_we",  {31'd0, reg_we}, 32'd0);
            chk("br halted",  {31'd0, halted}, 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("br rst fault", {31'd0, fault}, 32'd0);
        chk("br rst state", {29'd0, state}, 32'd0);

        // MEM_TIMEOUT=4: five not-ready FETCH cycles then FAULT
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("to4 fetch state", {29'd0, t4_state}, 32'd0);
            chk("to4 fetch ir_we", {31'd0, t4_ir_we}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk("to4 fault state", {29'd0, t4_state}, 32'd6);
        chk("to4 fault flag",  {31'd0, t4_fault}, 32'd1);
        chk("to4 fault ir_we", {31'd0, t4_ir_we}, 32'd0);

        // MEM_TIMEOUT=4: ready on the fifth wait cycle completes normally
        do_reset();
        opcode = 7'b0010011;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to4b fetch state", {29'd0, t4_state}, 32'd0);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        chk("to4b ir_we", {31'd0, t4_ir_we}, 32'd1);
        @(negedge clk); #1;
        chk("to4b decode", {29'd0, t4_state}, 32'd1);

        // Halt requested during EXEC, then resume, then instret wrap
        do_reset();
        opcode = 7'b0010011; dec_reg_write = 1'b1; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        halt_req = 1'b1;
        #1;
        chk("halt exec state", {29'd0, state}, 32'd2);
        @(negedge clk); #1;
        chk("halt wb state",  {29'd0, state}, 32'd4);
        chk("halt wb pc_we",  {31'd0, pc_we}, 32'd1);
        chk("halt wb halted", {31'd0, halted}, 32'd0);
        @(negedge clk); #1;
        chk("halt state",   {29'd0, state}, 32'd5);
        chk("halt halted",  {31'd0, halted}, 32'd1);
        chk("halt instret", instret, 32'd1);
        chk("halt mem_req", {31'd0, mem_req}, 32'd0);
        chk("halt ir_we",   {31'd0, ir_we}, 32'd0);
        @(negedge clk); #1;
        chk("halt hold", {29'd0, state}, 32'd5);
        halt_req = 1'b0;
        @(negedge clk); #1;
        chk("resume state",  {29'd0, state}, 32'd0);
        chk("resume halted", {31'd0, halted}, 32'd0);
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        #1;
        chk("wrap preload", instret, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        #1;
        chk("wrap wb state", {29'd0, state}, 32'd4);
        @(negedge clk); #1;
        chk("wrap instret", instret, 32'd0);
        chk("wrap state",   {29'd0, state}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
